// File: rtl/psum_wb_ctrl_pkg.sv
// rtl/psum_wb_ctrl_pkg.sv - shared state encoding and mode bit indices for the PSUM writeback sequencer
package psum_wb_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_POP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int MODE_PT   = 2;
    localparam int MODE_ACC  = 1;
    localparam int MODE_RELU = 0;

    // Passthrough is the only mode whose SFP result ignores the stored partial sum.
    function automatic logic needs_psum(input logic [2:0] m);
        return !m[MODE_PT];
    endfunction

endpackage

// File: rtl/psum_wb_ctrl_if.sv
// rtl/psum_wb_ctrl_if.sv - OFIFO, SFP and PSUM SRAM signals seen by the writeback sequencer
interface psum_wb_ctrl_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
) ();

    logic                     ofifo_valid;
    logic                     ofifo_rd;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic [col*psum_bw-1:0]   ofifo_q;
    logic [2:0]               sfp_mode;
    logic                     sram_cen;
    logic                     sram_wen;
    logic [addr_w-1:0]        sram_addr;

    modport master (
        input  ofifo_valid,
        input  ofifo_out,
        output ofifo_rd,
        output ofifo_q,
        output sfp_mode,
        output sram_cen,
        output sram_wen,
        output sram_addr
    );

    modport slave (
        output ofifo_valid,
        output ofifo_out,
        input  ofifo_rd,
        input  ofifo_q,
        input  sfp_mode,
        input  sram_cen,
        input  sram_wen,
        input  sram_addr
    );

endinterface

// File: rtl/psum_wb_ctrl.sv
// rtl/psum_wb_ctrl.sv - pops OFIFO vectors, reads the matching partial sum and writes the SFP result back
module psum_wb_ctrl
    import psum_wb_ctrl_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int cnt_w   = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   base_addr,
    input  logic [cnt_w-1:0]    num_vec,
    input  logic [2:0]          mode,
    psum_wb_ctrl_if.master      bus,
    output logic                busy,
    output logic                done
);

    state_e                   state_q, state_d;
    logic [addr_w-1:0]        addr_q, addr_d;
    logic [cnt_w-1:0]         rem_q, rem_d;
    logic [2:0]               mode_q, mode_d;
    logic [col*psum_bw-1:0]   vec_q, vec_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
        end
    end

    // WAIT is skipped whenever the FIFO already holds data, giving two cycles per vector.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = num_vec;
                    mode_d = mode;
                    if (num_vec == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.ofifo_valid) begin
                        state_d = ST_POP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.ofifo_valid) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                vec_d   = bus.ofifo_out;
                state_d = ST_WR;
            end
            ST_WR: begin
                addr_d = addr_q + addr_w'(1);
                rem_d  = rem_q - cnt_w'(1);
                if (rem_q == cnt_w'(1)) begin
                    state_d = ST_DONE;
                end else if (bus.ofifo_valid) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode from the state register only, so no input reaches them combinationally.
    always_comb begin
        bus.ofifo_rd  = (state_q == ST_POP);
        bus.sram_cen  = !(((state_q == ST_POP) && needs_psum(mode_q)) || (state_q == ST_WR));
        bus.sram_wen  = !(state_q == ST_WR);
        bus.sram_addr = addr_q;
        bus.ofifo_q   = vec_q;
        bus.sfp_mode  = mode_q;
        busy          = (state_q == ST_WAIT) || (state_q == ST_POP) || (state_q == ST_WR);
        done          = (state_q == ST_DONE);
    end

endmodule
